// File: rtl/avr_uart_loader_if.sv
// Purpose: bundles the loader's UART receive, UART transmit and program-memory buses.
// Latency: none; this file only declares wires.
// Backpressure: tx_ready is the only back-pressure signal. The receive stream has none.
// Ports (master = loader side):
//   rx_data/rx_valid   byte stream from the UART receiver
//   tx_data/tx_strobe  reply byte to the UART transmitter, gated by tx_ready
//   pm_we/pm_a/pm_d    program-memory word write port
interface avr_uart_loader_if #(
  parameter int PM_AW = 16
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       tx_data;
  logic             tx_strobe;
  logic             tx_ready;
  logic             pm_we;
  logic [PM_AW-1:0] pm_a;
  logic [15:0]      pm_d;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_strobe, pm_we, pm_a, pm_d
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_strobe, pm_we, pm_a, pm_d
  );
endinterface

// File: rtl/avr_uart_loader.sv
// Purpose: parses 'L' load frames from the UART byte stream and writes words to program memory.
//          It replies ACK or NAK to each frame. 'G' releases the AVR core from reset.
// Latency: a word write issues 1 cycle after its high byte arrives. The reply issues
//          1 cycle after the checksum byte, or once tx_ready allows it.
// Backpressure: the machine waits in REPLY while tx_ready=0. Bytes received there are dropped.
// Ports:
//   clk, rst      single clock; synchronous active-high reset
//   bus           avr_uart_loader_if.master (rx stream, tx reply, program-memory write)
//   core_rst      holds the AVR core in reset while 1
//   busy          1 whenever the parser is not in IDLE
module avr_uart_loader #(
  parameter logic [23:0] TIMEOUT = 24'd1000000,
  parameter int          PM_AW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  avr_uart_loader_if.master bus,
  output logic              core_rst,
  output logic              busy
);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_GO   = 8'h47;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_L, S_ADDR_H, S_LEN, S_DATA_L, S_DATA_H, S_CSUM, S_REPLY
  } state_t;

  state_t           state_q, state_d;
  logic             core_rst_q, core_rst_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       addr_lo_q, addr_lo_d;
  logic [7:0]       data_lo_q, data_lo_d;
  logic [8:0]       wcnt_q, wcnt_d;
  logic [23:0]      tcnt_q, tcnt_d;
  logic [PM_AW-1:0] pm_a_q, pm_a_d;
  logic [15:0]      pm_d_q, pm_d_d;
  logic             pm_we_q, pm_we_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_strobe;

  logic [7:0]  sum_plus;
  logic [8:0]  wcnt_dec;
  logic [23:0] tcnt_inc;
  logic        framing;
  logic        timeout_hit;

  assign sum_plus = sum_q + bus.rx_data;
  assign wcnt_dec = wcnt_q - 9'd1;
  assign tcnt_inc = tcnt_q + 24'd1;
  // The inter-byte timer runs only while a frame is open. It is not armed in IDLE or in REPLY.
  assign framing     = (state_q != S_IDLE) && (state_q != S_REPLY);
  assign timeout_hit = framing && !bus.rx_valid && (tcnt_inc == TIMEOUT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.rx_valid && bus.rx_data == CMD_LOAD) state_d = S_ADDR_L;
      S_ADDR_L: if (bus.rx_valid) state_d = S_ADDR_H;
      S_ADDR_H: if (bus.rx_valid) state_d = S_LEN;
      S_LEN:    if (bus.rx_valid) state_d = S_DATA_L;
      S_DATA_L: if (bus.rx_valid) state_d = S_DATA_H;
      S_DATA_H: if (bus.rx_valid) state_d = (wcnt_dec == 9'd0) ? S_CSUM : S_DATA_L;
      S_CSUM:   if (bus.rx_valid) state_d = S_REPLY;
      S_REPLY:  if (bus.tx_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_REPLY;
  end

  // Output and datapath logic
  always_comb begin
    core_rst_d = core_rst_q;
    sum_d      = sum_q;
    addr_lo_d  = addr_lo_q;
    data_lo_d  = data_lo_q;
    wcnt_d     = wcnt_q;
    pm_a_d     = pm_a_q;
    pm_d_d     = pm_d_q;
    pm_we_d    = 1'b0;
    tx_data_d  = tx_data_q;
    tx_strobe  = 1'b0;
    tcnt_d     = 24'd0;

    // The address advances on the edge that ends the write pulse, so pm_a is stable during pm_we.
    if (pm_we_q) pm_a_d = pm_a_q + PM_AW'(1);

    if (framing) tcnt_d = bus.rx_valid ? 24'd0 : tcnt_inc;
    if (timeout_hit) tx_data_d = NAK;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && bus.rx_data == CMD_LOAD) begin
          core_rst_d = 1'b1;
          sum_d      = 8'd0;
        end else if (bus.rx_valid && bus.rx_data == CMD_GO) begin
          core_rst_d = 1'b0;
        end
      end
      S_ADDR_L: if (bus.rx_valid) begin
        addr_lo_d = bus.rx_data;
        sum_d     = sum_plus;
      end
      S_ADDR_H: if (bus.rx_valid) begin
        pm_a_d = PM_AW'({bus.rx_data, addr_lo_q});
        sum_d  = sum_plus;
      end
      S_LEN: if (bus.rx_valid) begin
        // LEN=0 encodes a full 256-word frame.
        wcnt_d = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
        sum_d  = sum_plus;
      end
      S_DATA_L: if (bus.rx_valid) begin
        data_lo_d = bus.rx_data;
        sum_d     = sum_plus;
      end
      S_DATA_H: if (bus.rx_valid) begin
        pm_d_d  = {bus.rx_data, data_lo_q};
        pm_we_d = 1'b1;
        wcnt_d  = wcnt_dec;
        sum_d   = sum_plus;
      end
      S_CSUM: if (bus.rx_valid) begin
        tx_data_d = (sum_plus == 8'd0) ? ACK : NAK;
      end
      S_REPLY: tx_strobe = bus.tx_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst_q <= 1'b0;
      sum_q      <= 8'd0;
      addr_lo_q  <= 8'd0;
      data_lo_q  <= 8'd0;
      wcnt_q     <= 9'd0;
      tcnt_q     <= 24'd0;
      pm_a_q     <= '0;
      pm_d_q     <= 16'd0;
      pm_we_q    <= 1'b0;
      tx_data_q  <= 8'd0;
    end else begin
      core_rst_q <= core_rst_d;
      sum_q      <= sum_d;
      addr_lo_q  <= addr_lo_d;
      data_lo_q  <= data_lo_d;
      wcnt_q     <= wcnt_d;
      tcnt_q     <= tcnt_d;
      pm_a_q     <= pm_a_d;
      pm_d_q     <= pm_d_d;
      pm_we_q    <= pm_we_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_strobe = tx_strobe;
  assign bus.pm_we     = pm_we_q;
  assign bus.pm_a      = pm_a_q;
  assign bus.pm_d      = pm_d_q;
  assign core_rst      = core_rst_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_avr_uart_loader.sv
// Purpose: randomized bench for avr_uart_loader, checked against a frame-level reference model.
// Latency: the bench drives inputs 1 time unit after posedge and samples outputs on negedge.
// Backpressure: the bench toggles tx_ready to exercise the REPLY wait.
module tb_avr_uart_loader;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst, busy;

  avr_uart_loader_if #(.PM_AW(16)) bus();

  avr_uart_loader #(.TIMEOUT(24'd100), .PM_AW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .core_rst(core_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rx = 0;
  int last_tx = 0;
  logic [31:0] wr_q[$];
  logic [7:0]  tx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observed-transaction monitor: write pulses, reply strobes and byte timing.
  // last_rx records the edge number that will sample the byte.
  always @(negedge clk) begin
    if (bus.rx_valid) last_rx = cyc + 1;
    if (bus.pm_we) wr_q.push_back({bus.pm_a, bus.pm_d});
    if (bus.tx_strobe) begin
      tx_q.push_back(bus.tx_data);
      last_tx = cyc;
    end
  end

  task automatic drive(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic send(input bq_t f);
    int g;
    foreach (f[i]) begin
      drive(f[i]);
      g = $urandom_range(0, 2);
      if (g != 0) quiet(g);
    end
    quiet(1);
  endtask

  task automatic wait_tx(input int max);
    int k = 0;
    while (tx_q.size() == 0 && k < max) begin
      @(posedge clk);
      k++;
    end
  endtask

  task automatic mk(input logic [15:0] a, input logic [7:0] len, input bit good, output bq_t f);
    int n;
    logic [7:0] s, b, cs;
    f = {8'h4C, a[7:0], a[15:8], len};
    n = (len == 8'd0) ? 256 : int'(len);
    s = a[7:0] + a[15:8] + len;
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      s = s + b;
    end
    cs = 8'd0 - s;
    if (!good) cs = cs + 8'($urandom_range(1, 255));
    f.push_back(cs);
  endtask

  // Reference model: decode the whole frame as a byte list.
  // Expected writes are consecutive 16-bit addresses that wrap. The reply depends on the byte sum.
  task automatic run_frame(input string tag, input bq_t f);
    int n;
    logic [15:0] a, ea;
    logic [7:0] s, rep;
    a = {f[2], f[1]};
    n = (f[3] == 8'd0) ? 256 : int'(f[3]);
    s = f[1] + f[2] + f[3];
    for (int i = 0; i < 2 * n; i++) s = s + f[4 + i];
    s = s + f[4 + 2 * n];
    rep = (s == 8'd0) ? 8'h06 : 8'h15;
    wr_q.delete();
    tx_q.delete();
    send(f);
    wait_tx(50);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, "_wr_cnt"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      ea = a + 16'(i);
      check({tag, "_wr"}, wr_q[i], {ea, f[5 + 2 * i], f[4 + 2 * i]});
    end
    check({tag, "_tx_cnt"}, tx_q.size(), 1);
    if (tx_q.size() > 0) check({tag, "_reply"}, tx_q[0], rep);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_core_rst"}, core_rst, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t f;
    int t_rise;
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_pm_we", bus.pm_we, 0);
    check("rst_pm_a", bus.pm_a, 0);
    check("rst_pm_d", bus.pm_d, 0);
    check("rst_tx_strobe", bus.tx_strobe, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_core_rst", core_rst, 0);
    check("rst_busy", busy, 0);

    // Two-word frame. The checksum complement of this frame is 0xDA.
    f = {8'h4C, 8'h10, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDA};
    run_frame("two_good", f);
    f = {8'h4C, 8'h10, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h25};
    run_frame("two_bad", f);

    // A 256-word frame whose addresses wrap through 0xFFFF.
    mk(16'hFFFF, 8'h00, 1'b1, f);
    run_frame("wrap", f);

    for (int k = 0; k < 6; k++) begin
      mk(16'($urandom), 8'($urandom_range(1, 6)), bit'($urandom_range(0, 1)), f);
      run_frame("rand", f);
    end

    // Ignored byte in IDLE
    tx_q.delete();
    drive(8'h41);
    quiet(3);
    @(negedge clk);
    check("ign_busy", busy, 0);
    check("ign_core_rst", core_rst, 1);
    check("ign_tx", tx_q.size(), 0);

    // Release the core
    drive(8'h47);
    quiet(1);
    @(negedge clk);
    check("go_core_rst", core_rst, 0);
    quiet(5);
    check("go_tx", tx_q.size(), 0);

    // Inter-byte timeout
    wr_q.delete();
    tx_q.delete();
    drive(8'h4C);
    quiet(1);
    drive(8'h00);
    quiet(1);
    wait_tx(200);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("to_tx_cnt", tx_q.size(), 1);
    if (tx_q.size() > 0) check("to_reply", tx_q[0], 8'h15);
    check("to_delay", last_tx - last_rx, 100);
    check("to_wr", wr_q.size(), 0);
    check("to_busy", busy, 0);
    check("to_core_rst", core_rst, 1);

    // Reset in the middle of a frame
    wr_q.delete();
    tx_q.delete();
    drive(8'h4C);
    quiet(1);
    drive(8'h00);
    quiet(1);
    @(negedge clk);
    check("mid_busy_pre", busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_core_rst", core_rst, 0);
    check("mid_busy", busy, 0);
    quiet(150);
    check("mid_tx", tx_q.size(), 0);
    check("mid_wr", wr_q.size(), 0);

    // tx_ready held low. Bytes that arrive while the reply waits are dropped.
    mk(16'h0200, 8'h02, 1'b1, f);
    wr_q.delete();
    tx_q.delete();
    @(posedge clk); #1 bus.tx_ready = 1'b0;
    send(f);
    drive(8'h4C); quiet(2);
    drive(8'h47); drive(8'h00); quiet(1);
    drive(8'h4C); quiet(1);
    quiet(40);
    @(negedge clk);
    check("bp_tx_wait", tx_q.size(), 0);
    check("bp_busy_wait", busy, 1);
    @(posedge clk); #1 bus.tx_ready = 1'b1;
    t_rise = cyc;
    wait_tx(20);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_tx_cnt", tx_q.size(), 1);
    if (tx_q.size() > 0) check("bp_reply", tx_q[0], 8'h06);
    check("bp_tx_cycle", last_tx, t_rise);
    check("bp_busy", busy, 0);
    check("bp_core_rst", core_rst, 1);
    check("bp_wr", wr_q.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
